// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the digit-serial ALU.
// Pure declarations: no logic, no latency.
package alu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arithmetic-mode B operand select, driven by s[1:0]
    localparam logic [1:0] BSEL_B    = 2'b00;
    localparam logic [1:0] BSEL_NB   = 2'b01;
    localparam logic [1:0] BSEL_ZERO = 2'b10;
    localparam logic [1:0] BSEL_ONES = 2'b11;

    // Bit positions inside the function select
    localparam int S_USE_FLAG = 2;
    localparam int S_RSVD     = 3;

endpackage

// File: rtl/alu_serial_nbit_digit.sv
// One DIGIT-bit combinational ALU slice: Toffoli/double-XOR carry chain in arithmetic mode,
// 4-entry truth-table lookup per bit in logic mode. Zero latency, no flow control.
module alu_digit
    import alu_serial_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic [DIGIT-1:0] f,
    output logic             cout,
    output logic             ctop
);

    logic [DIGIT-1:0] bp;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] p;

    always_comb begin
        case (s[1:0])
            BSEL_B:    bp = b;
            BSEL_NB:   bp = ~b;
            BSEL_ZERO: bp = '0;
            BSEL_ONES: bp = '1;
            default:   bp = b;
        endcase
    end

    // Carry chain written in reversible-gate form: a Toffoli on (a, b') xored with
    // a Toffoli on (c, a^b'), which equals the usual majority carry.
    always_comb begin
        c    = '0;
        p    = '0;
        f    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            p[i]   = a[i] ^ bp[i];
            c[i+1] = (a[i] & bp[i]) ^ (c[i] & p[i]);
            f[i]   = m ? s[{a[i], b[i]}] : (p[i] ^ c[i]);
        end
    end

    assign cout = m ? 1'b0 : c[DIGIT];
    assign ctop = m ? 1'b0 : c[DIGIT-1];

endmodule

// File: rtl/alu_serial_nbit.sv
// Digit-serial N-bit ALU: accepts one op in IDLE, result valid WIDTH/DIGIT edges later.
// Result and flags are held in DONE until out_ready; no new op is accepted until then.
module alu_serial_nbit
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             carry_flag
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] f_sh;
    logic [3:0]       s_r;
    logic             m_r;
    logic             c_r;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_f;
    logic             d_cout;
    logic             d_ctop;
    logic [WIDTH-1:0] f_nxt;
    logic             last;
    logic             accept;
    logic             eff_cin;

    assign accept  = in_valid & in_ready;
    assign last    = (cnt == CW'(N - 1));
    assign eff_cin = s[S_USE_FLAG] ? carry_flag : cin;
    // Result digits enter at the top and walk down, so after N shifts digit 0 sits at the LSB
    assign f_nxt   = (f_sh >> DIGIT) | (WIDTH'(d_f) << (WIDTH - DIGIT));

    alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .s    (s_r),
        .m    (m_r),
        .cin  (c_r),
        .f    (d_f),
        .cout (d_cout),
        .ctop (d_ctop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            f_sh       <= '0;
            s_r        <= '0;
            m_r        <= 1'b0;
            c_r        <= 1'b0;
            cnt        <= '0;
            f          <= '0;
            cout       <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        a_sh     <= a;
                        b_sh     <= b;
                        f_sh     <= '0;
                        s_r      <= s;
                        m_r      <= m;
                        c_r      <= eff_cin;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    f_sh <= f_nxt;
                    c_r  <= d_cout;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        f         <= f_nxt;
                        zero      <= (f_nxt == '0);
                        cout      <= d_cout;
                        ovf       <= d_ctop ^ d_cout;
                        // Logic ops leave the chained carry untouched
                        if (!m_r) begin
                            carry_flag <= d_cout;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Randomized and directed checks of alu_serial_nbit against an arithmetic reference model.
module tb_alu_serial_nbit;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
    logic             ovf;
    logic             carry_flag;

    int checks = 0;
    int errors = 0;

    logic       mdl_cf;
    logic [7:0] obs_f;
    logic       obs_cout;
    logic       obs_zero;
    logic       obs_ovf;

    alu_serial_nbit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .s          (s),
        .m          (m),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f          (f),
        .cout       (cout),
        .zero       (zero),
        .ovf        (ovf),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] ms,
                         input logic mm, input logic mcin, input logic mcf,
                         output logic [7:0] ef, output logic ecout, output logic eovf,
                         output logic ezero, output logic ecf);
        logic [7:0] bp;
        logic [8:0] sum;
        logic [7:0] low;
        logic       ci;
        if (mm) begin
            ef = ({8{ms[0]}} & ~ma & ~mb) | ({8{ms[1]}} & ~ma & mb) |
                 ({8{ms[2]}} &  ma & ~mb) | ({8{ms[3]}} &  ma & mb);
            ecout = 1'b0;
            eovf  = 1'b0;
            ecf   = mcf;
        end else begin
            case (ms[1:0])
                2'b00:   bp = mb;
                2'b01:   bp = ~mb;
                2'b10:   bp = 8'h00;
                default: bp = 8'hFF;
            endcase
            ci    = ms[2] ? mcf : mcin;
            sum   = {1'b0, ma} + {1'b0, bp} + {8'h00, ci};
            low   = {1'b0, ma[6:0]} + {1'b0, bp[6:0]} + {7'h00, ci};
            ef    = sum[7:0];
            ecout = sum[8];
            eovf  = low[7] ^ sum[8];
            ecf   = sum[8];
        end
        ezero = (ef == 8'h00);
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] ts,
                         input logic tm, input logic tcin, input int hold);
        logic [7:0] ef;
        logic       ecout, eovf, ezero, ecf;
        model(ta, tbv, ts, tm, tcin, mdl_cf, ef, ecout, eovf, ezero, ecf);
        check("idle_in_ready", in_ready, 1);
        a = ta; b = tbv; s = ts; m = tm; cin = tcin; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must have no effect
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
        repeat (N - 1) @(posedge clk);
        #1;
        check("lat_early_valid", out_valid, 0);
        check("run_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_valid", out_valid, 1);
        check("f", f, ef);
        check("cout", cout, ecout);
        check("ovf", ovf, eovf);
        check("zero", zero, ezero);
        check("carry_flag", carry_flag, ecf);
        obs_f = f; obs_cout = cout; obs_zero = zero; obs_ovf = ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            a = 8'($urandom);
            @(posedge clk); #1;
            check("hold_f", f, ef);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        out_ready = 1'b0;
        mdl_cf = ecf;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
        mdl_cf = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_flags", {cout, zero, ovf, carry_flag}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h3C, 4'b0000, 1'b0, 1'b0, 0);
        check("tp_add_f", obs_f, 8'h96);
        check("tp_add_ovf", obs_ovf, 1);
        do_op(8'h10, 8'h10, 4'b0001, 1'b0, 1'b1, 0);
        check("tp_sub_zero", {obs_zero, obs_cout, obs_f}, {2'b11, 8'h00});
        do_op(8'hF0, 8'hAA, 4'b0110, 1'b1, 1'b0, 1);
        check("tp_xor_f", obs_f, 8'h5A);
        check("tp_xor_cf", carry_flag, 1);
        do_op(8'hFF, 8'h01, 4'b0000, 1'b0, 1'b0, 0);
        check("tp_chain1", {obs_cout, obs_f}, {1'b1, 8'h00});
        do_op(8'h00, 8'h00, 4'b0100, 1'b0, 1'b0, 0);
        check("tp_chain2", {obs_cout, obs_f}, {1'b0, 8'h01});
        do_op(8'h33, 8'h44, 4'b0000, 1'b0, 1'b1, 5);

        // Reset in the middle of RUN
        a = 8'h7F; b = 8'h01; s = 4'b0000; m = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_f", f, 0);
        check("midrst_cf", carry_flag, 0);
        #2;
        rst = 1'b0;
        mdl_cf = 1'b0;
        do_op(8'h5A, 8'h3C, 4'b0000, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
